// File: rtl/ni_clock_synchro_mc.sv
// ni_clock_synchro_mc
//   Multi-channel clock-beat synchroniser. Each channel divides clk by a
//   run-time programmable ratio and flags the first and last beat of every
//   divided period. New ratios are loaded through a load/ack handshake and
//   only take effect on a period boundary, so no period is ever truncated.
//   A global resync realigns every channel to the start of a period.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active-low
//   enable           per-channel count enable
//   clkdiv_in        new divider values, channel i at [i*CNT_WD +: CNT_WD]
//   div_load         per-channel one-cycle request to capture a new divider
//   div_ack          per-channel one-cycle pulse: new divider now active
//   resync           synchronous global realign
//   last_clock_beat  per-channel final cycle of the current divided period
//   first_clock_beat per-channel first cycle of the current divided period
//   phase            per-channel current period counter
module ni_clock_synchro_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_WD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH*CNT_WD-1:0] clkdiv_in,
  input  logic [NUM_CH-1:0]        div_load,
  output logic [NUM_CH-1:0]        div_ack,
  input  logic                     resync,
  output logic [NUM_CH-1:0]        last_clock_beat,
  output logic [NUM_CH-1:0]        first_clock_beat,
  output logic [NUM_CH*CNT_WD-1:0] phase
);

  localparam logic [CNT_WD-1:0] ONE = CNT_WD'(1);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WD-1:0] cnt_reg;
      logic [CNT_WD-1:0] div_reg;
      logic [CNT_WD-1:0] pend_reg;
      logic              pend_v_reg;
      logic              ack_reg;

      logic [CNT_WD-1:0] div_eff;
      logic              last_beat;
      logic              bnd;
      logic              apply;

      // A stored ratio of 0 behaves as divide-by-1.
      assign div_eff   = (div_reg == '0) ? ONE : div_reg;
      assign last_beat = (cnt_reg == div_eff - ONE);

      // A disabled channel sits on a boundary every cycle, so a pending
      // ratio is applied on the next edge without waiting for a count.
      assign bnd   = resync | ~enable[gi] | last_beat;
      // A load on the same edge wins: it is only captured, never applied.
      assign apply = pend_v_reg & bnd & ~div_load[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg    <= '0;
          div_reg    <= ONE;
          pend_reg   <= '0;
          pend_v_reg <= 1'b0;
          ack_reg    <= 1'b0;
        end else begin
          ack_reg <= apply;

          // Applying a ratio always opens a fresh period at count 0.
          if (resync || apply) begin
            cnt_reg <= '0;
          end else if (enable[gi]) begin
            if (last_beat) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + ONE;
            end
          end

          if (div_load[gi]) begin
            pend_reg   <= clkdiv_in[gi*CNT_WD +: CNT_WD];
            pend_v_reg <= 1'b1;
          end else if (apply) begin
            div_reg    <= pend_reg;
            pend_v_reg <= 1'b0;
          end
        end
      end

      assign last_clock_beat[gi]          = last_beat;
      assign first_clock_beat[gi]         = (cnt_reg == '0);
      assign div_ack[gi]                  = ack_reg;
      assign phase[gi*CNT_WD +: CNT_WD]   = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ni_clock_synchro_mc.sv
// tb_ni_clock_synchro_mc
//   Self-checking bench for ni_clock_synchro_mc: a directed vector table for
//   channel 0, hand-written sequences for the multi-cycle corner cases, and a
//   randomized run checked against a behavioural reference model.
module tb_ni_clock_synchro_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_WD = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH*CNT_WD-1:0] clkdiv_in;
  logic [NUM_CH-1:0]        div_load;
  logic [NUM_CH-1:0]        div_ack;
  logic                     resync;
  logic [NUM_CH-1:0]        last_clock_beat;
  logic [NUM_CH-1:0]        first_clock_beat;
  logic [NUM_CH*CNT_WD-1:0] phase;

  ni_clock_synchro_mc #(.NUM_CH(NUM_CH), .CNT_WD(CNT_WD)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .clkdiv_in        (clkdiv_in),
    .div_load         (div_load),
    .div_ack          (div_ack),
    .resync           (resync),
    .last_clock_beat  (last_clock_beat),
    .first_clock_beat (first_clock_beat),
    .phase            (phase)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: per-channel period position, ratio and pending ratio.
  int m_cnt [NUM_CH];
  int m_div [NUM_CH];
  int m_pend[NUM_CH];
  int m_pv  [NUM_CH];
  int m_ack [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_div[i] = 1; m_pend[i] = 0; m_pv[i] = 0; m_ack[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      int  ratio;
      bit  at_end, boundary, applied;
      ratio    = (m_div[i] == 0) ? 1 : m_div[i];
      at_end   = (m_cnt[i] == ratio - 1);
      boundary = resync || !enable[i] || at_end;
      applied  = (m_pv[i] != 0) && boundary && !div_load[i];
      if (resync || applied) m_cnt[i] = 0;
      else if (enable[i])    m_cnt[i] = (m_cnt[i] + 1) % ratio;
      if (div_load[i]) begin
        m_pend[i] = int'(clkdiv_in[i*CNT_WD +: CNT_WD]);
        m_pv[i]   = 1;
      end else if (applied) begin
        m_div[i] = m_pend[i];
        m_pv[i]  = 0;
      end
      m_ack[i] = applied ? 1 : 0;
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH-1:0]        e_last, e_first, e_ack;
    logic [NUM_CH*CNT_WD-1:0] e_phase;
    for (int i = 0; i < NUM_CH; i++) begin
      int ratio;
      ratio      = (m_div[i] == 0) ? 1 : m_div[i];
      e_last[i]  = (m_cnt[i] == ratio - 1);
      e_first[i] = (m_cnt[i] == 0);
      e_ack[i]   = (m_ack[i] != 0);
      e_phase[i*CNT_WD +: CNT_WD] = CNT_WD'(m_cnt[i]);
    end
    check("model_last",  32'(last_clock_beat),  32'(e_last));
    check("model_first", 32'(first_clock_beat), 32'(e_first));
    check("model_ack",   32'(div_ack),          32'(e_ack));
    check("model_phase", phase,                 e_phase);
  endtask

  // One transaction: clock edge, model update, compare, one line of trace.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    $display("t=%0t en=%b ld=%b rs=%b div=%h | phase=%h ack=%b last=%b first=%b",
             $time, enable, div_load, resync, clkdiv_in, phase, div_ack,
             last_clock_beat, first_clock_beat);
  endtask

  function automatic logic [CNT_WD-1:0] ph(input int ch);
    return phase[ch*CNT_WD +: CNT_WD];
  endfunction

  typedef struct {
    logic             en;
    logic             ld;
    logic [CNT_WD-1:0] val;
    logic             exp_ack;
    logic [CNT_WD-1:0] exp_ph;
    logic             exp_last;
    logic             exp_first;
  } vec_t;

  vec_t vecs[7];
  int   ack_cnt;

  initial begin
    // Channel 0: load 4 while disabled, then enable and watch a full period.
    vecs[0] = '{1'b0, 1'b1, 8'd4, 1'b0, 8'd0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};

    rst = 1'b0; enable = '0; clkdiv_in = '0; div_load = '0; resync = 1'b0;
    model_reset();
    #1;
    check("reset_last",  32'(last_clock_beat),  32'hf);
    check("reset_first", 32'(first_clock_beat), 32'hf);
    check("reset_ack",   32'(div_ack),          32'h0);
    check("reset_phase", phase,                 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    enable = 4'hf;

    // All channels at divide-by-1.
    for (int k = 0; k < 3; k++) begin
      step();
      check("div1_last",  32'(last_clock_beat),  32'hf);
      check("div1_first", 32'(first_clock_beat), 32'hf);
      check("div1_phase", phase,                 32'h0);
    end

    // Vector table on channel 0, other channels idle.
    for (int v = 0; v < 7; v++) begin
      enable          = {3'b000, vecs[v].en};
      div_load        = {3'b000, vecs[v].ld};
      clkdiv_in       = '0;
      clkdiv_in[7:0]  = vecs[v].val;
      step();
      check("tbl_ack",   32'(div_ack[0]),          32'(vecs[v].exp_ack));
      check("tbl_phase", 32'(ph(0)),               32'(vecs[v].exp_ph));
      check("tbl_last",  32'(last_clock_beat[0]),  32'(vecs[v].exp_last));
      check("tbl_first", 32'(first_clock_beat[0]), 32'(vecs[v].exp_first));
    end
    div_load = '0;

    // Channel 1: run at 5, reprogram to 3 mid-period.
    div_load[1] = 1'b1; clkdiv_in[15:8] = 8'd5;
    step();
    div_load[1] = 1'b0;
    step();
    check("ch1_ack5", 32'(div_ack[1]), 32'h1);
    enable[1] = 1'b1;
    step();
    check("ch1_ph1", 32'(ph(1)), 32'd1);
    div_load[1] = 1'b1; clkdiv_in[15:8] = 8'd3;
    step();
    div_load[1] = 1'b0;
    check("ch1_ph2", 32'(ph(1)), 32'd2);
    step(); check("ch1_ph3", 32'(ph(1)), 32'd3);
    step(); check("ch1_ph4", 32'(ph(1)), 32'd4);
    check("ch1_noack", 32'(div_ack[1]), 32'h0);
    step(); check("ch1_ph0", 32'(ph(1)), 32'd0);
    check("ch1_ack3", 32'(div_ack[1]), 32'h1);
    step(); check("ch1_p3a", 32'(ph(1)), 32'd1);
    step(); check("ch1_p3b", 32'(ph(1)), 32'd2);
    check("ch1_last3", 32'(last_clock_beat[1]), 32'h1);
    step(); check("ch1_p3c", 32'(ph(1)), 32'd0);

    // Channel 2: load 6 then 2 back to back; one ack, ratio 2.
    ack_cnt = 0;
    div_load[2] = 1'b1; clkdiv_in[23:16] = 8'd6;
    step(); ack_cnt += int'(div_ack[2]);
    clkdiv_in[23:16] = 8'd2;
    step(); ack_cnt += int'(div_ack[2]);
    div_load[2] = 1'b0;
    enable[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      ack_cnt += int'(div_ack[2]);
      if (div_ack[2]) check("ch2_ack_ph0", 32'(ph(2)), 32'd0);
      else            check("ch2_ratio2",  32'(last_clock_beat[2]), 32'(ph(2) == 8'd1));
    end
    check("ch2_one_ack", 32'(ack_cnt), 32'd1);

    // Channel 3: ratio 0 behaves as divide-by-1.
    div_load[3] = 1'b1; clkdiv_in[31:24] = 8'd0;
    step();
    div_load[3] = 1'b0; enable[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ch3_last",  32'(last_clock_beat[3]),  32'h1);
      check("ch3_first", 32'(first_clock_beat[3]), 32'h1);
    end

    // Resync with channel 0 holding a pending load from the previous cycle.
    step();
    div_load[0] = 1'b1; clkdiv_in[7:0] = 8'd5;
    step();
    div_load[0] = 1'b0; resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_phase", phase, 32'h0);
    check("rs_ack0",  32'(div_ack[0]), 32'h1);

    // Asynchronous reset mid-period.
    step(); step();
    check("pre_rst_ph0", 32'(ph(0)), 32'd2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_phase", phase, 32'h0);
    check("arst_last",  32'(last_clock_beat),  32'hf);
    check("arst_first", 32'(first_clock_beat), 32'hf);
    check("arst_ack",   32'(div_ack), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized run against the model.
    for (int k = 0; k < 400; k++) begin
      enable   = NUM_CH'($urandom);
      resync   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        div_load[i] = ($urandom_range(0, 9) == 0);
        clkdiv_in[i*CNT_WD +: CNT_WD] = CNT_WD'($urandom_range(0, 7));
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ni_clock_synchro_mc.md
Name: ni_clock_synchro_mc

Overview:
- Multi-channel, run-time reprogrammable successor to the NI clock-beat synchroniser.
- Each of NUM_CH independent channels divides clk by a per-channel ratio and flags the first and last beat of every divided period.
- New divider values are loaded through a load/ack handshake and take effect only on a period boundary, so no truncated periods occur.
- A global resync realigns all channels. Used by NIs that bridge to several slower link or flit clock domains at once.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- CNT_WD, 8, width of divider value and period counter per channel (>=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous reset, active-low
- enable  input  NUM_CH  per-channel count enable
- clkdiv_in  input  NUM_CH*CNT_WD  new divider values; channel i uses bits [i*CNT_WD +: CNT_WD]
- div_load  input  NUM_CH  per-channel one-cycle request to capture clkdiv_in slice
- div_ack  output  NUM_CH  one-cycle pulse: new divider now active
- resync  input  1  synchronous global realign
- last_clock_beat  output  NUM_CH  final cycle of current divided period
- first_clock_beat  output  NUM_CH  first cycle of current divided period
- phase  output  NUM_CH*CNT_WD  current period counter per channel

Behaviour:
- Per-channel registers:
  - cnt (CNT_WD)
  - div_r (CNT_WD, active ratio)
  - pend_r (CNT_WD)
  - pend_v (1)
  - ack_r (1)
- Reset (rst=0, asynchronous): cnt=0, div_r=1, pend_r=0, pend_v=0, ack_r=0.
  - Consequence: last_clock_beat=all 1s, first_clock_beat=all 1s, div_ack=0, phase=0.
- Effective ratio: div_eff = (div_r==0) ? 1 : div_r. A value of 0 is legal and means divide-by-1.
- Beat outputs are combinational from registers only and are independent of enable:
  - last_clock_beat[i] = (cnt == div_eff-1)
  - first_clock_beat[i] = (cnt == 0)
  - For div_eff=1, both are constantly 1.
- Counter, per channel, in priority order at each edge:
  1. resync=1: cnt<=0 for every channel, regardless of enable.
  2. enable=1 and last_clock_beat: cnt<=0.
  3. enable=1: cnt<=cnt+1.
  4. enable=0: cnt holds.
- Boundary, per channel: bnd = resync | !enable | (enable & last_clock_beat).
- Load handshake:
  - div_load=1 at an edge: pend_r<=clkdiv_in slice, pend_v<=1.
  - A second load before apply overwrites pend_r. Only one ack follows.
- Apply:
  - At an edge with pend_v=1, bnd=1 and div_load=0: div_r<=pend_r, pend_v<=0, ack_r<=1.
  - At all other edges: ack_r<=0.
  - A load coinciding with a boundary is captured only; it is applied at the next boundary, never the same edge.
  - div_ack = ack_r, high for exactly the first cycle of the new period.
- Latency:
  - Disabled channel: div_load at edge N -> applied at edge N+1 -> div_ack high in cycle N+1..N+2.
  - Enabled channel: applied at the first terminal-beat edge after the load edge.
- Apply changes div_r and resets cnt together. The period after an apply always starts at cnt=0 with the new ratio.
- Shrinking the ratio while cnt is already past the new terminal value is impossible, because apply occurs only at a boundary.
- Channels are fully independent except for resync.
- cnt never exceeds div_eff-1 while enabled. It wraps only via the terminal-beat rule, never by overflow.

Test Plan:
- Reset then release, CNT_WD=8, enable=1111, no load -> all beats high every cycle (div=1), phase=0, div_ack=0.
- Ch0: load 4 while disabled, then enable -> div_ack[0] pulses one cycle; phase[0] sequence 0,1,2,3,0; last[0] high on 3, first[0] high on 0; period 4 cycles.
- Ch1 running div=5, load 3 at phase 1 -> div 5 period completes (phase 2,3,4); div_ack[1] pulses at new phase 0; subsequent periods are 3 cycles.
- Ch2 loads 6 then 2 before boundary -> single div_ack; active ratio becomes 2; value 6 never observed.
- Ch3 load 0 -> treated as divide-by-1; last[3]=first[3]=1 continuously.
- Ch0 div=4 and ch1 div=3 at arbitrary phases, assert resync one cycle -> both phases 0 next cycle. Pending load plus resync on the same edge (load cycle earlier) -> applied and acked on the resync edge. Asynchronous reset asserted mid-period -> immediate return to reset values.
